// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode and state encodings, flag bit positions and
//               small helpers for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_MOD  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_COPY = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_DIV  = 4'b1000,
        OP_SRL  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // True for the two opcodes served by the iterative divider.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Places the four independent flag bits at their fixed positions.
    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_div.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_div
// Description : Unsigned restoring divider, one quotient bit per cycle.
//               Quotient and remainder are final, and done is raised, N
//               cycles after the start pulse. The divisor must be non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_div
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_dsr;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_done;

    logic [N:0]    w_shift;
    logic          w_ge;
    logic [N-1:0]  w_rem_next;

    // One restoring step: shift in the next dividend bit and try to subtract.
    // The partial remainder stays below the divisor, so the N-bit wrap-around
    // difference is exact whenever the subtraction is kept.
    always_comb begin
        w_shift    = {r_rem, r_quo[N-1]};
        w_ge       = (w_shift >= {1'b0, r_dsr});
        w_rem_next = w_ge ? (w_shift[N-1:0] - r_dsr) : w_shift[N-1:0];
    end

    // Iteration registers; the quotient is built in place of the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_quo  <= dividend;
            r_rem  <= '0;
            r_dsr  <= divisor;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[N-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle ALU with valid/ready handshakes. Single-cycle
//               ops finish one cycle after acceptance; MUL (shift-add) and
//               DIV/MOD (restoring divider) take N iterations and finish
//               N+1 cycles after acceptance. Produces N/Z/C/V flags and a
//               divide-by-zero indication.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ctrl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         div_by_zero
);

    localparam int           CW          = $clog2(N + 1);
    localparam logic [N-1:0] SHIFT_LIMIT = N'(N);

    alu_state_e      r_state;
    alu_state_e      w_state_next;

    // Operands are captured at acceptance; r_pending marks the cycle in which
    // the captured request is decoded and either completed or launched.
    logic            r_pending;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [3:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [2*N-1:0]  r_prod;
    logic [N-1:0]    r_result;
    logic [3:0]      r_flags;
    logic            r_dbz;

    logic            w_accept;
    logic            w_is_long;
    logic            w_busy_last;
    logic            w_div_start;
    logic [N-1:0]    w_div_quo;
    logic [N-1:0]    w_div_rem;
    logic            w_div_done;

    logic [N:0]      w_add;
    logic [N-1:0]    w_sub;
    logic [N-1:0]    w_s_res;
    logic            w_s_c;
    logic            w_s_v;
    logic            w_s_dbz;

    logic [N:0]      w_prod_sum;
    logic [2*N-1:0]  w_prod_next;
    logic [N-1:0]    w_l_res;
    logic            w_l_c;

    assign in_ready    = (r_state == IDLE) && !r_pending;
    assign out_valid   = (r_state == DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_is_long   = (r_op == OP_MUL) || (is_div_op(r_op) && (r_b != '0));
    // The divider is loaded straight from the ports on the accept edge so its
    // N iterations are complete by the last BUSY cycle.
    assign w_div_start = w_accept && is_div_op(ctrl) && (b != '0);
    assign w_busy_last = (r_state == BUSY) && (r_cnt == CW'(N - 1)) &&
                         (!is_div_op(r_op) || w_div_done);

    alu_seq_div #(
        .N (N)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (a),
        .divisor   (b),
        .quotient  (w_div_quo),
        .remainder (w_div_rem),
        .done      (w_div_done)
    );

    // Single-cycle results, including the divide-by-zero shortcut.
    always_comb begin
        w_add   = {1'b0, r_a} + {1'b0, r_b};
        w_sub   = r_a - r_b;
        w_s_res = '0;
        w_s_c   = 1'b0;
        w_s_v   = 1'b0;
        w_s_dbz = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_s_res = w_add[N-1:0];
                w_s_c   = w_add[N];
                w_s_v   = (r_a[N-1] == r_b[N-1]) && (w_add[N-1] != r_a[N-1]);
            end
            OP_SUB: begin
                w_s_res = w_sub;
                w_s_c   = (r_a < r_b);
                w_s_v   = (r_a[N-1] != r_b[N-1]) && (w_sub[N-1] != r_a[N-1]);
            end
            OP_OR:   w_s_res = r_a | r_b;
            OP_AND:  w_s_res = r_a & r_b;
            OP_COPY: w_s_res = r_b;
            OP_SLL:  w_s_res = (r_b >= SHIFT_LIMIT) ? '0 : (r_a << r_b);
            OP_SRL:  w_s_res = (r_b >= SHIFT_LIMIT) ? '0 : (r_a >> r_b);
            OP_DIV: begin
                w_s_res = '1;
                w_s_dbz = 1'b1;
            end
            OP_MOD: begin
                w_s_res = r_a;
                w_s_dbz = 1'b1;
            end
            default: w_s_res = '0;
        endcase
    end

    // Shift-add multiplier step and selection of the iterative result.
    always_comb begin
        w_prod_sum  = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_a} : '0);
        w_prod_next = {w_prod_sum, r_prod[N-1:1]};
        w_l_res     = w_div_quo;
        w_l_c       = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_l_res = w_prod_next[N-1:0];
                w_l_c   = |w_prod_next[2*N-1:N];
            end
            OP_MOD:  w_l_res = w_div_rem;
            default: w_l_res = w_div_quo;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_state_next = w_is_long ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_busy_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_dbz     <= 1'b0;
        end else begin
            r_pending <= w_accept;
            if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= ctrl;
            end
            if ((r_state == IDLE) && r_pending) begin
                if (w_is_long) begin
                    r_cnt  <= '0;
                    r_prod <= {{N{1'b0}}, r_b};
                end else begin
                    r_result <= w_s_res;
                    r_flags  <= pack_flags(w_s_res[N-1], (w_s_res == '0), w_s_c, w_s_v);
                    r_dbz    <= w_s_dbz;
                end
            end
            if (r_state == BUSY) begin
                r_cnt  <= r_cnt + CW'(1);
                r_prod <= w_prod_next;
                if (w_busy_last) begin
                    r_result <= w_l_res;
                    r_flags  <= pack_flags(w_l_res[N-1], (w_l_res == '0), w_l_c, 1'b0);
                    r_dbz    <= 1'b0;
                end
            end
        end
    end

    assign result      = r_result;
    assign flags       = r_flags;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Scoreboard bench for alu_seq. A driver issues directed and
//               random operations and queues the modelled response; an
//               independent monitor pops and checks each result, its
//               latency and its stability while held.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int N = 8;
    localparam longint M = longint'(1) << N;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flg;
        logic         dbz;
        int           acc;
        int           lat;
        bit           hold;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic         div_by_zero;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   seen  = 0;

    alu_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .ctrl        (ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [N-1:0] ai,
                                   input logic [N-1:0] bi);
        exp_t   e;
        longint ua, ub, sa, sb_, full, r, sr;
        bit     c, v, d;
        ua = longint'(ai);
        ub = longint'(bi);
        sa = (ua >= M / 2) ? ua - M : ua;
        sb_ = (ub >= M / 2) ? ub - M : ub;
        c = 0; v = 0; d = 0; r = 0;
        case (op)
            4'd0: begin
                full = ua + ub; r = full % M; c = (full >= M);
                sr = sa + sb_; v = (sr > M / 2 - 1) || (sr < -(M / 2));
            end
            4'd1: begin
                r = (ua - ub + M) % M; c = (ua < ub);
                sr = sa - sb_; v = (sr > M / 2 - 1) || (sr < -(M / 2));
            end
            4'd2: begin full = ua * ub; r = full % M; c = (full >= M); end
            4'd3: r = ua | ub;
            4'd4: begin if (ub == 0) begin r = ua; d = 1; end else r = ua % ub; end
            4'd5: r = ua & ub;
            4'd6: r = ub;
            4'd7: r = (ub >= N) ? 0 : (ua << ub) % M;
            4'd8: begin if (ub == 0) begin r = M - 1; d = 1; end else r = ua / ub; end
            4'd9: r = (ub >= N) ? 0 : (ua >> ub);
            default: r = 0;
        endcase
        e.res  = N'(r);
        e.flg  = {r >= M / 2, r == 0, c, v};
        e.dbz  = d;
        e.lat  = (op == 4'd2 || ((op == 4'd4 || op == 4'd8) && ub != 0)) ? N + 1 : 1;
        e.acc  = 0;
        e.hold = 0;
        return e;
    endfunction

    // Presents one request, waits (bounded) for acceptance and queues the
    // expected response. Returns on the falling edge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [N-1:0] ai,
                         input logic [N-1:0] bi, input bit hold);
        exp_t e;
        int   guard;
        @(negedge clk);
        in_valid = 1'b1; a = ai; b = bi; ctrl = op;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e      = model(op, ai, bi);
            e.acc  = cyc + 1;
            e.hold = hold;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = N'($urandom); b = N'($urandom); ctrl = 4'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || seen || out_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 0, 1);
    endtask

    // Monitor: checks each presented result once, then its stability until
    // the handshake it schedules completes.
    initial begin : monitor
        exp_t cur;
        int   hold;
        bit   unstable;
        out_ready = 1'b0;
        hold = 0;
        unstable = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                        out_ready = 1'b1;
                        continue;
                    end
                    cur = sb.pop_front();
                    seen = 1;
                    unstable = 0;
                    chk("result", result, cur.res);
                    chk("flags", flags, cur.flg);
                    chk("div_by_zero", div_by_zero, cur.dbz);
                    chk("latency", cyc - cur.acc, cur.lat);
                    hold = cur.hold ? 5 : $urandom_range(0, 2);
                end
                if (result !== cur.res || flags !== cur.flg ||
                    div_by_zero !== cur.dbz || in_ready !== 1'b0)
                    unstable = 1;
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    chk("held_stable", unstable, 0);
                    out_ready = 1'b1;
                    seen = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : driver
        logic [3:0]   op;
        logic [N-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctrl = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;

        // Directed cases.
        issue(4'd0, 8'h7F, 8'h01, 0);
        issue(4'd1, 8'h05, 8'h07, 0);
        issue(4'd1, 8'h80, 8'h01, 0);
        issue(4'd2, 8'h10, 8'h10, 1);
        issue(4'd2, 8'd12, 8'd10, 0);
        issue(4'd8, 8'd200, 8'd7, 0);
        issue(4'd4, 8'd200, 8'd7, 0);
        issue(4'd8, 8'd42, 8'd0, 0);
        issue(4'd4, 8'd42, 8'd0, 0);
        issue(4'd7, 8'h81, 8'd8, 0);
        issue(4'd9, 8'h81, 8'd7, 0);
        issue(4'd15, 8'hAA, 8'h55, 0);
        issue(4'd2, 8'hFF, 8'hFF, 0);

        // Randomised traffic, biased towards small b for shifts and b == 0.
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = N'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = N'($urandom_range(0, 9));
                1:       rb = '0;
                default: rb = N'($urandom);
            endcase
            issue(op, ra, rb, 0);
        end
        drain();

        // Reset during the third BUSY cycle of a division aborts it.
        issue(4'd8, 8'd200, 8'd7, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (sb.size() != 0) void'(sb.pop_back());
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        chk("abort_flags", flags, 0);
        chk("abort_dbz", div_by_zero, 0);
        rst = 1'b0;
        issue(4'd0, 8'd1, 8'd1, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $finish;
    end

endmodule
`default_nettype wire
